seq_detect_multi: RTL and testbench
===================================

Name: seq_detect_multi

Overview:
- Parametrised Mealy multi-pattern serial sequence detector; successor to the fixed 11/101/1011 detector.
- Consumes one qualified bit per cycle and compares it, together with the bit history, against NUM_PAT runtime-programmable patterns of up to MAX_LEN bits.
- Produces a combined hit, a per-pattern hit vector and a saturating hit count.
- Overlapping or non-overlapping detection is selected at runtime. The block sits between a serial bit source and control logic.

Parameters:
- NUM_PAT, 3: number of pattern slots (1..16).
- MAX_LEN, 4: maximum pattern length in bits (2..32).
- CNT_W, 8: hit counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in  in  1  serial data bit.
- in_valid  in  1  in is consumed this cycle.
- ovl_en  in  1  1 = overlapping detection; 0 = history cleared after every hit.
- clr  in  1  synchronous clear of history and hit_cnt (config kept).
- cfg_we  in  1  pattern slot write strobe.
- cfg_idx  in  $clog2(NUM_PAT) (min 1)  slot index.
- cfg_pat  in  MAX_LEN  pattern, LSB = most recent bit.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length.
- cfg_en  in  1  slot enable.
- cfg_err  out  1  registered pulse: last write rejected.
- z  out  1  combinational Mealy hit, the OR of hit_vec.
- hit_vec  out  NUM_PAT  combinational per-slot hit.
- hit_cnt  out  CNT_W  registered count of hit cycles.

Behaviour:
- Clocking and reset: single clock; reset is asynchronous and active-high; ports are named clk and rst.
- Reset state:
  - hist=0, fill=0, hit_cnt=0, cfg_err=0.
  - Slot0 = 2'b11 len2 en, slot1 = 3'b101 len3 en, slot2 = 4'b1011 len4 en (those that exist).
  - Remaining slots pat=0, len=0, disabled.
  - z and hit_vec therefore read 0 out of reset.
- hist is MAX_LEN-1 bits, shifted left with in at LSB on each consumed bit. fill counts bits received and saturates at MAX_LEN-1.
- Candidate window = {hist, in}. Slot k hits when all of the following hold:
  - in_valid=1 and clr=0;
  - en_k=1;
  - fill+1 >= len_k;
  - the low len_k bits of the window equal the low len_k bits of pat_k.
- Latency: zero. z and hit_vec are valid in the same cycle as in and depend combinationally on in/in_valid. With in_valid=0, all hits are 0 and no state changes.
- Post-hit update:
  - ovl_en=1: normal shift.
  - ovl_en=0 and z=1: hist<=0, fill<=0; the hitting bit is not retained.
- hit_cnt increments by 1 per cycle with z=1 (not per slot) and saturates at 2^CNT_W-1.
- clr=1 clears hist, fill and hit_cnt; any simultaneous in bit is discarded and z=0. clr has priority over in_valid.
- Config write on cfg_we:
  - Accepted when 1 <= cfg_len <= MAX_LEN and cfg_idx < NUM_PAT.
  - Otherwise the slot is unchanged and cfg_err=1 for one cycle.
  - New config applies from the next cycle; a same-cycle match uses the old config.
  - History is unaffected by config writes.
- Changing ovl_en mid-stream takes effect on the current cycle's post-hit update.
- rst asserted mid-operation aborts immediately to the reset state, including config.

Optional Feature:
- SEQDET_REG_OUT_EN defined: z and hit_vec are registered (Moore-style). They are asserted exactly one cycle after the hitting bit, reset to 0, and are cleared by clr. hit_cnt timing is unchanged.
- Undefined: purely combinational Mealy outputs as described above.

Decomposition:
- Package seq_detect_pkg: default pattern constants (DEF_PAT0..2, DEF_LEN0..2), a cfg slot struct typedef {pat, len, en}, and a length-mask function.
- One sub-module, seq_match_slot: combinational compare of one slot against the window and fill, instantiated NUM_PAT times via generate.

Test Plan:
1. After reset, defaults, ovl_en=1, stream 1,1,0,1,0,1,1 -> z=0,1,0,1,0,1,1; hit_vec on the last bit=3'b101; hit_cnt=4.
2. ovl_en=1, stream 1,1,1,1 -> z=0,1,1,1. ovl_en=0, same stream after clr -> z=0,1,0,1; hit_cnt=2.
3. in_valid=0 gaps inserted between bits of scenario 1 -> identical z per consumed bit, z=0 during gaps.
4. Write slot1 pat=4'b0110 len4 en; stream 0,1,1,0 -> hit_vec[1]=1 on the 4th bit only. Write with cfg_len=0 or MAX_LEN+1 -> cfg_err pulses, slot unchanged.
5. CNT_W=2, stream of 5 ones -> hit_cnt saturates at 3. clr together with in=1, in_valid=1 -> z=0 and hit_cnt=0 next cycle.
6. Assert rst asynchronously between edges mid-stream -> hit_cnt=0 and hist cleared immediately; defaults restored after a prior reprogram. Under SEQDET_REG_OUT_EN, scenario 1 outputs are delayed by one cycle.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared constants, slot configuration type and helpers for seq_detect_multi.
package seq_detect_pkg;

  localparam int PAT_W_MAX = 32;
  localparam int LEN_W_MAX = 6;

  localparam logic [PAT_W_MAX-1:0] DEF_PAT0 = 32'h3;
  localparam logic [PAT_W_MAX-1:0] DEF_PAT1 = 32'h5;
  localparam logic [PAT_W_MAX-1:0] DEF_PAT2 = 32'hB;
  localparam int DEF_LEN0 = 2;
  localparam int DEF_LEN1 = 3;
  localparam int DEF_LEN2 = 4;

  typedef struct packed {
    logic [PAT_W_MAX-1:0] pat;
    logic [LEN_W_MAX-1:0] len;
    logic                 en;
  } cfg_slot_t;

  function automatic logic [PAT_W_MAX-1:0] len_mask(input logic [LEN_W_MAX-1:0] len);
    if (len >= LEN_W_MAX'(PAT_W_MAX)) return '1;
    return (PAT_W_MAX'(1) << len) - PAT_W_MAX'(1);
  endfunction

  // A default pattern longer than the configured MAX_LEN leaves its slot disabled.
  function automatic cfg_slot_t default_slot(input int k, input int max_len);
    cfg_slot_t s;
    s = '0;
    case (k)
      0: if (DEF_LEN0 <= max_len) s = '{pat: DEF_PAT0, len: LEN_W_MAX'(DEF_LEN0), en: 1'b1};
      1: if (DEF_LEN1 <= max_len) s = '{pat: DEF_PAT1, len: LEN_W_MAX'(DEF_LEN1), en: 1'b1};
      2: if (DEF_LEN2 <= max_len) s = '{pat: DEF_PAT2, len: LEN_W_MAX'(DEF_LEN2), en: 1'b1};
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seq_match_slot.sv
// Combinational compare of one pattern slot against the candidate window.
module seq_match_slot
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = 4,
  parameter int LEN_W   = 3
) (
  input  logic               act_i,
  input  logic [MAX_LEN-1:0] window_i,
  input  logic [LEN_W-1:0]   fill_i,
  input  logic [MAX_LEN-1:0] pat_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic               en_i,
  output logic               hit_o
);

  logic [PAT_W_MAX-1:0] diff;
  logic                 enough;

  assign diff   = PAT_W_MAX'(window_i ^ pat_i) & len_mask(LEN_W_MAX'(len_i));
  // fill counts bits already in history; the current bit makes it fill+1.
  assign enough = ({1'b0, fill_i} + 1'b1) >= {1'b0, len_i};
  assign hit_o  = act_i & en_i & enough & (diff == '0);

endmodule

// File: rtl/seq_detect_multi.sv
// Multi-pattern serial sequence detector with runtime-programmable slots.
// Define SEQDET_REG_OUT_EN to register z and hit_vec (one cycle later).
module seq_detect_multi
  import seq_detect_pkg::*;
#(
  parameter int NUM_PAT = 3,
  parameter int MAX_LEN = 4,
  parameter int CNT_W   = 8,
  localparam int IDX_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic               ovl_en,
  input  logic               clr,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_en,
  output logic               cfg_err,
  output logic               z,
  output logic [NUM_PAT-1:0] hit_vec,
  output logic [CNT_W-1:0]   hit_cnt
);

  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cfg_err_q;
  logic [MAX_LEN-1:0] window;
  logic [NUM_PAT-1:0] hit_c;
  logic               z_c, act, cfg_ok;

  assign act    = in_valid & ~clr;
  assign window = {hist_q, in};
  assign z_c    = |hit_c;
  assign cfg_ok = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN) && (int'(cfg_idx) < NUM_PAT);

  for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_slot
    localparam cfg_slot_t DEF_K = default_slot(gi, MAX_LEN);
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               en_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pat_q <= DEF_K.pat[MAX_LEN-1:0];
        len_q <= DEF_K.len[LEN_W-1:0];
        en_q  <= DEF_K.en;
      end else if (cfg_we && cfg_ok && (int'(cfg_idx) == gi)) begin
        pat_q <= cfg_pat;
        len_q <= cfg_len;
        en_q  <= cfg_en;
      end
    end

    seq_match_slot #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_match (
      .act_i   (act),
      .window_i(window),
      .fill_i  (fill_q),
      .pat_i   (pat_q),
      .len_i   (len_q),
      .en_i    (en_q),
      .hit_o   (hit_c[gi])
    );
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (clr) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (in_valid) begin
      // Non-overlapping mode drops the hitting bit along with the history.
      if (z_c && !ovl_en) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[MAX_LEN-2:0];
        fill_d = (int'(fill_q) >= MAX_LEN - 1) ? fill_q : fill_q + 1'b1;
      end
      if (z_c && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q    <= '0;
      fill_q    <= '0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_we & ~cfg_ok;
    end
  end

  assign cfg_err = cfg_err_q;
  assign hit_cnt = cnt_q;

`ifdef SEQDET_REG_OUT_EN
  logic [NUM_PAT-1:0] hit_vec_q;
  logic               z_q;

  // hit_c is already zero under clr, so the registers clear with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_vec_q <= '0;
      z_q       <= 1'b0;
    end else begin
      hit_vec_q <= hit_c;
      z_q       <= z_c;
    end
  end

  assign hit_vec = hit_vec_q;
  assign z       = z_q;
`else
  assign hit_vec = hit_c;
  assign z       = z_c;
`endif

endmodule

// File: tb/tb_seq_detect_multi.sv
// Directed table-driven bench for seq_detect_multi plus hand-written corner sequences.
module tb_seq_detect_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_b = 1'b0, in_valid = 1'b0, ovl_en = 1'b1, clr = 1'b0;
  logic       cfg_we = 1'b0, cfg_en = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [3:0] cfg_pat = '0;
  logic [2:0] cfg_len = '0;

  logic       cfg_err, z, cfg_err2, z2;
  logic [2:0] hit_vec, hit_vec2;
  logic [7:0] hit_cnt;
  logic [1:0] hit_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_multi #(.NUM_PAT(3), .MAX_LEN(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid), .ovl_en(ovl_en), .clr(clr),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_en(cfg_en),
    .cfg_err(cfg_err), .z(z), .hit_vec(hit_vec), .hit_cnt(hit_cnt)
  );

  seq_detect_multi #(.NUM_PAT(3), .MAX_LEN(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid), .ovl_en(ovl_en), .clr(clr),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pat(cfg_pat), .cfg_len(cfg_len), .cfg_en(cfg_en),
    .cfg_err(cfg_err2), .z(z2), .hit_vec(hit_vec2), .hit_cnt(hit_cnt2)
  );

  typedef struct {
    logic       b, v, c, o, ez;
    logic [2:0] hv;
    int         cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void add(input logic b, v, c, o, ez, input logic [2:0] hv, input int cnt);
    vec_t r;
    r.b = b; r.v = v; r.c = c; r.o = o; r.ez = ez; r.hv = hv; r.cnt = cnt;
    tbl.push_back(r);
  endfunction

  // Drive one cycle; Mealy outputs sampled before the edge, registered ones after it.
  task automatic step(input logic b, v, c, o, ez, input logic [2:0] hv, input int cnt, input string nm);
    @(negedge clk);
    in_b = b; in_valid = v; clr = c; ovl_en = o;
    #1;
`ifndef SEQDET_REG_OUT_EN
    chk({nm, " z"}, int'(z), int'(ez));
    chk({nm, " hit_vec"}, int'(hit_vec), int'(hv));
`endif
    @(posedge clk);
    #1;
`ifdef SEQDET_REG_OUT_EN
    chk({nm, " z"}, int'(z), int'(ez));
    chk({nm, " hit_vec"}, int'(hit_vec), int'(hv));
`endif
    chk({nm, " hit_cnt"}, int'(hit_cnt), cnt);
    $display("step %s in=%0b v=%0b clr=%0b ovl=%0b z=%0b hv=%03b cnt=%0d", nm, b, v, c, o, z, hit_vec, hit_cnt);
    cfg_we = 1'b0; in_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [3:0] pat, input logic [2:0] len,
                           input logic en, input int cnt, input logic exp_err, input string nm);
    cfg_we = 1'b1; cfg_idx = idx; cfg_pat = pat; cfg_len = len; cfg_en = en;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, cnt, nm);
    chk({nm, " cfg_err"}, int'(cfg_err), int'(exp_err));
  endtask

  task automatic stream0110(input string nm);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 0, {nm, " clr"});
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 0, {nm, " b1"});
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 0, {nm, " b2"});
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 1, {nm, " b3"});
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 2, {nm, " b4"});
  endtask

  initial begin
    // Overlapping stream 1,1,0,1,0,1,1 straight out of reset.
    add(1,1,0,1,0,3'b000,0); add(1,1,0,1,1,3'b001,1); add(0,1,0,1,0,3'b000,1);
    add(1,1,0,1,1,3'b010,2); add(0,1,0,1,0,3'b000,2); add(1,1,0,1,1,3'b010,3);
    add(1,1,0,1,1,3'b101,4);
    // Ones, overlapping then non-overlapping.
    add(1,1,1,1,0,3'b000,0);
    add(1,1,0,1,0,3'b000,0); add(1,1,0,1,1,3'b001,1); add(1,1,0,1,1,3'b001,2); add(1,1,0,1,1,3'b001,3);
    add(1,1,1,0,0,3'b000,0);
    add(1,1,0,0,0,3'b000,0); add(1,1,0,0,1,3'b001,1); add(1,1,0,0,0,3'b000,1); add(1,1,0,0,1,3'b001,2);
    // First stream again with idle gaps carrying in=1.
    add(1,1,1,1,0,3'b000,0);
    add(1,1,0,1,0,3'b000,0); add(1,0,0,1,0,3'b000,0); add(1,1,0,1,1,3'b001,1); add(1,0,0,1,0,3'b000,1);
    add(0,1,0,1,0,3'b000,1); add(1,0,0,1,0,3'b000,1); add(1,1,0,1,1,3'b010,2); add(1,0,0,1,0,3'b000,2);
    add(0,1,0,1,0,3'b000,2); add(1,0,0,1,0,3'b000,2); add(1,1,0,1,1,3'b010,3); add(1,0,0,1,0,3'b000,3);
    add(1,1,0,1,1,3'b101,4);

    repeat (2) @(negedge clk);
    #1;
    chk("reset z", int'(z), 0);
    chk("reset hit_vec", int'(hit_vec), 0);
    chk("reset hit_cnt", int'(hit_cnt), 0);
    chk("reset cfg_err", int'(cfg_err), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].b, tbl[i].v, tbl[i].c, tbl[i].o, tbl[i].ez, tbl[i].hv, tbl[i].cnt, $sformatf("vec%0d", i));
    end

    // Reprogram slot1 to 0110 and check rejected writes leave it alone.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 0, "pre-cfg clr");
    cfg_write(2'd1, 4'b0110, 3'd4, 1'b1, 0, 1'b0, "cfg good");
    stream0110("new slot1");
    cfg_write(2'd1, 4'b0001, 3'd0, 1'b1, 2, 1'b1, "cfg len0");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 2, "idle");
    chk("cfg_err pulse end", int'(cfg_err), 0);
    cfg_write(2'd1, 4'b0001, 3'd5, 1'b1, 2, 1'b1, "cfg len5");
    cfg_write(2'd3, 4'b0001, 3'd2, 1'b1, 2, 1'b1, "cfg idx3");
    stream0110("kept slot1");

    // Saturation on the 2-bit counter, then clr racing a hitting bit.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 0, "sat clr");
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, (k > 0), (k > 0) ? 3'b001 : 3'b000, k, $sformatf("ones%0d", k));
      chk($sformatf("ones%0d hit_cnt2", k), int'(hit_cnt2), (k > 3) ? 3 : k);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 0, "clr with bit");
    chk("clr hit_cnt2", int'(hit_cnt2), 0);

    // Asynchronous reset mid-stream restores defaults.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 0, "pre-rst b1");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 1, "pre-rst b2");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst hit_cnt", int'(hit_cnt), 0);
    chk("async rst hit_cnt2", int'(hit_cnt2), 0);
    chk("async rst z", int'(z), 0);
    chk("async rst hit_vec", int'(hit_vec), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 0, "post-rst b1");
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 0, "post-rst b2");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 1, "post-rst b3");

    // A write to slot0 in the hitting cycle still matches with the old config.
    cfg_we = 1'b1; cfg_idx = 2'd0; cfg_pat = 4'b0011; cfg_len = 3'd2; cfg_en = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b101, 2, "same-cycle cfg");
    chk("same-cycle cfg_err", int'(cfg_err), 0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 2, "slot0 disabled");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
